// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one signed W x W multiplier among NUM_REQ requesters.
// Optional macro MULT_SHARE_ROUND_EN: p_hi is the rounded, saturated Q1.(W-1) result instead of the truncated top word.
module mult_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int W       = 18
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sync_in,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*W-1:0]   a_in,
    input  logic [NUM_REQ*W-1:0]   b_in,
    output logic [NUM_REQ-1:0]     gnt,
    output logic signed [2*W-1:0]  p_out,
    output logic signed [W-1:0]    p_hi,
    output logic                   p_valid,
    output logic [1:0]             p_tag
);

    logic [1:0]            r_ptr;
    logic signed [W-1:0]   r_op_a;
    logic signed [W-1:0]   r_op_b;
    logic [1:0]            r_tag1;
    logic                  r_v1;

    logic [1:0]            w_start;
    logic [1:0]            w_idx;
    logic                  w_any;
    logic [NUM_REQ-1:0]    w_gnt;
    logic signed [W-1:0]   w_sel_a;
    logic signed [W-1:0]   w_sel_b;
    logic signed [2*W-1:0] w_prod;
    logic signed [W-1:0]   w_hi;

    function automatic logic [1:0] f_wrap(input logic [1:0] base, input int offs);
        int t;
        t = int'(base) + offs;
        if (t >= NUM_REQ) t = t - NUM_REQ;
        return 2'(t);
    endfunction

    // sync_in restarts the search at requester 0 in the same cycle it is seen
    always_comb begin
        w_start = sync_in ? 2'd0 : r_ptr;
        w_idx   = '0;
        w_any   = 1'b0;
        for (int o = 0; o < NUM_REQ; o++) begin
            if (!w_any && req[f_wrap(w_start, o)]) begin
                w_idx = f_wrap(w_start, o);
                w_any = 1'b1;
            end
        end
        if (reset) w_any = 1'b0;
        w_gnt = w_any ? (NUM_REQ'(1) << w_idx) : '0;
    end

    assign gnt = w_gnt;

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_a = a_in[i*W +: W];
                w_sel_b = b_in[i*W +: W];
            end
        end
    end

    assign w_prod = (2*W)'(r_op_a) * (2*W)'(r_op_b);

`ifdef MULT_SHARE_ROUND_EN
    localparam logic signed [2*W-1:0] RND    = {{(W+1){1'b0}}, 1'b1, {(W-2){1'b0}}};
    localparam logic signed [2*W-1:0] HI_MAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W-1:0] HI_MIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};
    logic signed [2*W-1:0] w_rnd;
    logic signed [2*W-1:0] w_shr;

    // Only -2^(W-1) * -2^(W-1) can exceed the positive limit after scaling
    always_comb begin
        w_rnd = w_prod + RND;
        w_shr = w_rnd >>> (W-1);
        if (w_shr > HI_MAX)      w_hi = {1'b0, {(W-1){1'b1}}};
        else if (w_shr < HI_MIN) w_hi = {1'b1, {(W-1){1'b0}}};
        else                     w_hi = w_shr[W-1:0];
    end
`else
    assign w_hi = w_prod[2*W-1:W];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr   <= '0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_tag1  <= '0;
            r_v1    <= 1'b0;
            p_out   <= '0;
            p_hi    <= '0;
            p_tag   <= '0;
            p_valid <= 1'b0;
        end else begin
            if (w_any)        r_ptr <= f_wrap(w_idx, 1);
            else if (sync_in) r_ptr <= '0;
            r_v1 <= w_any;
            if (w_any) begin
                r_op_a <= w_sel_a;
                r_op_b <= w_sel_b;
                r_tag1 <= w_idx;
            end
            p_valid <= r_v1;
            if (r_v1) begin
                p_out <= w_prod;
                p_hi  <= w_hi;
                p_tag <= r_tag1;
            end
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: grant tables, directed corner sequences and a
// randomized run, all checked against a transaction-level reference model.
module tb_mult_share_arbiter;
    localparam int N = 4;
    localparam int W = 18;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  sync_in = 1'b0;
    logic [N-1:0]          req = '0;
    logic [N*W-1:0]        a_in = '0;
    logic [N*W-1:0]        b_in = '0;
    logic [N-1:0]          gnt;
    logic signed [2*W-1:0] p_out;
    logic signed [W-1:0]   p_hi;
    logic                  p_valid;
    logic [1:0]            p_tag;

    always #5 clk = ~clk;

    mult_share_arbiter #(.NUM_REQ(N), .W(W)) dut (
        .clk(clk), .reset(reset), .sync_in(sync_in), .req(req),
        .a_in(a_in), .b_in(b_in), .gnt(gnt), .p_out(p_out),
        .p_hi(p_hi), .p_valid(p_valid), .p_tag(p_tag)
    );

    typedef struct {int due; longint prod; longint hi; int tag;} txn_t;
    typedef struct {logic [3:0] req; logic sync; logic [3:0] exp_gnt;} vec_t;

    int     n_chk = 0;
    int     n_fail = 0;
    int     cyc = 0;
    int     m_ptr = 0;
    txn_t   q[$];
    longint last_prod = 0;
    longint last_hi = 0;
    int     last_tag = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic longint model_hi(input longint p);
`ifdef MULT_SHARE_ROUND_EN
        longint r;
        r = (p + (longint'(1) << (W-2))) >>> (W-1);
        if (r > (longint'(1) << (W-1)) - 1) r = (longint'(1) << (W-1)) - 1;
        if (r < -(longint'(1) << (W-1)))    r = -(longint'(1) << (W-1));
        return r;
`else
        return p >>> W;
`endif
    endfunction

    function automatic int model_pick(input logic [3:0] r, input logic s, input int ptr);
        int start;
        start = s ? 0 : ptr;
        for (int o = 0; o < N; o++)
            if (r[(start + o) % N]) return (start + o) % N;
        return -1;
    endfunction

    function automatic logic [N*W-1:0] rnd_ops();
        logic [N*W-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
        return v;
    endfunction

    // One clock cycle: drive, check against the model, advance the model
    task automatic step(input logic [3:0] r, input logic s,
                        input logic [N*W-1:0] a, input logic [N*W-1:0] b, output int g);
        int k;
        logic [3:0] eg;
        logic signed [W-1:0] sa, sb;
        longint pr;
        req = r; sync_in = s; a_in = a; b_in = b;
        #1;
        k  = model_pick(r, s, m_ptr);
        eg = (k < 0) ? 4'd0 : 4'(1 << k);
        chk("gnt", longint'(gnt), longint'(eg));
        if (q.size() > 0 && q[0].due == cyc) begin
            last_prod = q[0].prod; last_hi = q[0].hi; last_tag = q[0].tag;
            void'(q.pop_front());
            chk("p_valid", longint'(p_valid), 1);
        end else begin
            chk("p_valid", longint'(p_valid), 0);
        end
        chk("p_out", longint'(p_out), last_prod);
        chk("p_hi", longint'(p_hi), last_hi);
        chk("p_tag", longint'(p_tag), longint'(last_tag));
        if (k >= 0) begin
            sa = a[k*W +: W];
            sb = b[k*W +: W];
            pr = longint'(sa) * longint'(sb);
            q.push_back('{due: cyc + 2, prod: pr, hi: model_hi(pr), tag: k});
            m_ptr = (k + 1) % N;
        end else if (s) begin
            m_ptr = 0;
        end
        g = k;
        @(posedge clk); cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        int g;
        for (int i = 0; i < n; i++) step(4'd0, 1'b0, rnd_ops(), rnd_ops(), g);
    endtask

    task automatic do_reset();
        reset = 1'b1; req = 4'hF; sync_in = 1'b0;
        #1;
        chk("rst_gnt", longint'(gnt), 0);
        chk("rst_p_valid", longint'(p_valid), 0);
        chk("rst_p_out", longint'(p_out), 0);
        chk("rst_p_hi", longint'(p_hi), 0);
        chk("rst_p_tag", longint'(p_tag), 0);
        q.delete(); last_prod = 0; last_hi = 0; last_tag = 0; m_ptr = 0;
        repeat (2) begin @(posedge clk); cyc++; end
        @(negedge clk);
        reset = 1'b0; req = '0;
    endtask

    initial begin
        vec_t tab_rr[3];
        vec_t tab_sync[4];
        int g;
        logic signed [W-1:0] va, vb;
        logic [N*W-1:0] pa, pb;

        tab_rr[0]   = '{4'b0101, 1'b0, 4'b0001};
        tab_rr[1]   = '{4'b0101, 1'b0, 4'b0100};
        tab_rr[2]   = '{4'b0101, 1'b0, 4'b0001};
        tab_sync[0] = '{4'b1111, 1'b0, 4'b0001};
        tab_sync[1] = '{4'b1111, 1'b0, 4'b0010};
        tab_sync[2] = '{4'b1111, 1'b1, 4'b0001};
        tab_sync[3] = '{4'b1111, 1'b0, 4'b0010};

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 3; i++) begin
            step(tab_rr[i].req, tab_rr[i].sync, rnd_ops(), rnd_ops(), g);
            chk("tab_rr_gnt", longint'(g < 0 ? 0 : (1 << g)), longint'(tab_rr[i].exp_gnt));
        end
        idle(2);
        idle(5);

        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(tab_sync[i].req, tab_sync[i].sync, rnd_ops(), rnd_ops(), g);
            chk("tab_sync_gnt", longint'(g < 0 ? 0 : (1 << g)), longint'(tab_sync[i].exp_gnt));
        end
        idle(3);

        // Known product from requester 1
        pa = rnd_ops(); pb = rnd_ops();
        va = -18'sd12940; vb = 18'sd77324;
        pa[1*W +: W] = va; pb[1*W +: W] = vb;
        step(4'b0010, 1'b0, pa, pb, g);
        idle(1);
        chk("known_valid", longint'(p_valid), 1);
        chk("known_p_out", longint'(p_out), -64'sd1000572560);
        chk("known_p_tag", longint'(p_tag), 1);
        idle(2);

        // Most negative operands squared
        pa = rnd_ops(); pb = rnd_ops();
        va = -18'sd131072;
        pa[0 +: W] = va; pb[0 +: W] = va;
        step(4'b0001, 1'b0, pa, pb, g);
        idle(1);
`ifdef MULT_SHARE_ROUND_EN
        chk("minneg_p_hi", longint'(p_hi), 131071);
`else
        chk("minneg_p_hi", longint'(p_hi), 65536);
`endif
        idle(2);

        for (int i = 0; i < 400; i++)
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0), rnd_ops(), rnd_ops(), g);
        idle(2);

        // Grant, then reset while that product is in flight
        step(4'b0100, 1'b0, rnd_ops(), rnd_ops(), g);
        do_reset();
        idle(4);
        step(4'b1111, 1'b0, rnd_ops(), rnd_ops(), g);
        chk("first_after_rst", longint'(g), 0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_share_arbiter.md
MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the multiplier, fixed range 2..4.
REQ-002 Parameter W, default 18, signed operand width; product width is 2*W.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sync_in  input  1  sample strobe (clk_en of the filter cascade); realigns round-robin priority.
REQ-006 req  input  NUM_REQ  per-requester multiply request, level; bit i = requester i.
REQ-007 a_in  input  NUM_REQ*W  signed operand A, requester i in bits [i*W +: W].
REQ-008 b_in  input  NUM_REQ*W  signed operand B, same packing as a_in.
REQ-009 gnt  output  NUM_REQ  one-hot grant, combinational from req and priority pointer.
REQ-010 p_out  output  2*W  signed full-precision product, registered.
REQ-011 p_hi  output  W  signed high word of product (see Configuration), registered.
REQ-012 p_valid  output  1  p_out/p_hi valid this cycle, one-cycle pulse per product.
REQ-013 p_tag  output  2  index of requester owning current p_out.

Function
REQ-014 gnt SHALL have at most one bit set; gnt = 0 when req = 0.
REQ-015 Arbitration SHALL be round-robin: search starts at pointer ptr, ascending modulo NUM_REQ, first set req bit wins.
REQ-016 On a grant to requester k, ptr SHALL update at the clock edge to (k+1) mod NUM_REQ; no grant leaves ptr unchanged.
REQ-017 sync_in high SHALL force the search start to 0 in that same cycle and set ptr to 1 if requester 0 granted, else 0 if nothing granted, else (k+1) mod NUM_REQ.
REQ-018 Handshake: requester holds req, a_in, b_in stable until it sees gnt bit set; transfer occurs at the edge ending the gnt cycle; requester may keep req high for back-to-back operations.
REQ-019 Stage 1: at the transfer edge, granted operands and index SHALL be registered (op_a, op_b, tag1, v1=1); v1=0 when no grant.
REQ-020 Stage 2: next edge, op_a*op_b (signed, full 2*W bits, no overflow possible) SHALL register into p_out, tag1 into p_tag, v1 into p_valid.
REQ-021 Latency: gnt in cycle N -> p_valid high in cycle N+2 with matching p_tag; throughput one product per cycle.
REQ-022 p_out/p_hi/p_tag SHALL hold last values while p_valid = 0.
REQ-023 Requester deasserting req in a cycle where it is not granted SHALL lose nothing and receive no product.
REQ-024 Index values with req bits >= NUM_REQ SHALL not exist; unused gnt bits tie to 0.

Reset
REQ-025 Reset asserted SHALL immediately clear ptr, op_a, op_b, tag1, v1, p_out, p_hi, p_tag to 0 and p_valid to 0, and force gnt to 0.
REQ-026 Reset mid-operation SHALL discard all in-flight products; no p_valid for operations granted before reset.
REQ-027 First grant after reset deassertion SHALL follow priority from requester 0.

Configuration
REQ-028 Macro MULT_SHARE_ROUND_EN selects p_hi computation.
REQ-029 Defined: p_hi = round-half-up of product[2W-2:W-1] (i.e. product scaled by 2^-(W-1), matching Q1.(W-1) coefficients), saturated to [-2^(W-1), 2^(W-1)-1].
REQ-030 Not defined: p_hi = product[2W-1:W] truncated, no rounding, no saturation.

Verification
REQ-031 req=4'b0101, ptr=0, hold three cycles -> gnt 0001, 0100, 0001; p_tag 0,2,0 with p_valid in cycles 2,3,4.
REQ-032 Requester 1 a=-12940, b=77324 granted cycle N -> cycle N+2 p_valid=1, p_out=-1000572560, p_tag=1.
REQ-033 req=4'b1111 with sync_in pulsed on third cycle -> gnt 0001, 0010, 0001 (realigned), 0010.
REQ-034 a=b=-131072 with MULT_SHARE_ROUND_EN -> p_hi=131071 (saturated); without macro -> p_hi=65536.
REQ-035 Reset asserted one cycle after a grant -> no p_valid afterwards, p_out=0, gnt=0 during reset; next grant from requester 0.
REQ-036 req=0 for 5 cycles -> gnt=0, p_valid=0, p_out unchanged.
